// File: rtl/seq_detector_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_detector_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_OVERLAP    = 1'b1;
    localparam logic MODE_NONOVERLAP = 1'b0;

    // A match in non-overlapping mode invalidates the history it consumed.
    function automatic logic drops_history(input logic mode);
        unique case (mode)
            MODE_OVERLAP:    return 1'b0;
            MODE_NONOVERLAP: return 1'b1;
            default:         return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern and overlap select.
// Optional don't-care mask per pattern bit when SEQ_DETECTOR_MASK_EN is defined.
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1001,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic             en,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DETECTOR_MASK_EN
    input  logic [PAT_W-1:0] mask_in,
`endif
    input  logic             clr,
    output logic             w,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int             FW       = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W);

    state_t           state;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] mask_eff;
    logic [PAT_W-1:0] next_hist;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_inc;
    logic             fill_ready;
    logic             hit;
    logic             match;

`ifdef SEQ_DETECTOR_MASK_EN
    logic [PAT_W-1:0] mask;
    assign mask_eff = mask;
`else
    assign mask_eff = '1;
`endif

    assign next_hist = {hist[PAT_W-2:0], b};
    // fill+1 >= PAT_W without widening fill: either already full or one short.
    assign fill_ready = (state == ST_RUN) || (fill == FILL_MAX - 1'b1);
    assign hit        = ((next_hist ^ pat) & mask_eff) == '0;
    assign match      = en && !clr && !pat_load && fill_ready && hit;
    assign fill_inc   = (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FILL;
            hist  <= '0;
            fill  <= '0;
            pat   <= PAT_RST;
`ifdef SEQ_DETECTOR_MASK_EN
            mask  <= '1;
`endif
            w     <= 1'b0;
            armed <= 1'b0;
        end else if (clr) begin
            state <= ST_FILL;
            hist  <= '0;
            fill  <= '0;
            w     <= 1'b0;
            armed <= 1'b0;
        end else if (pat_load) begin
            state <= ST_FILL;
            pat   <= pat_in;
`ifdef SEQ_DETECTOR_MASK_EN
            mask  <= mask_in;
`endif
            fill  <= '0;
            w     <= 1'b0;
            armed <= 1'b0;
        end else if (en) begin
            hist <= next_hist;
            w    <= match;
            if (match && drops_history(overlap)) begin
                state <= ST_FILL;
                fill  <= '0;
                armed <= 1'b0;
            end else begin
                state <= (fill_inc == FILL_MAX) ? ST_RUN : ST_FILL;
                fill  <= fill_inc;
                armed <= (fill_inc == FILL_MAX);
            end
        end else begin
            w <= 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .inc(match),
        .clr(clr),
        .cnt(match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboarded bench for seq_detector_param: 8-bit and 2-bit counter instances share stimulus.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       b = 1'b0;
    logic       en = 1'b0;
    logic       overlap = 1'b1;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       clr = 1'b0;

    logic       w, armed, w2, armed2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    typedef struct {
        logic       w;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        logic       armed;
    } exp_t;

    exp_t  q[$];
    int    errors = 0;
    int    checks = 0;
    string cur_test = "init";

    logic [3:0] m_hist, m_pat;
    int         m_fill, m_cnt, m_cnt2;
    logic       m_w, m_armed;

    always #5 clk = ~clk;

    seq_detector_param #(
        .PAT_W(4), .PAT_RST(4'b1001), .CNT_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .b(b), .en(en), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DETECTOR_MASK_EN
        .mask_in(4'b1111),
`endif
        .clr(clr), .w(w), .match_cnt(match_cnt), .armed(armed)
    );

    seq_detector_param #(
        .PAT_W(4), .PAT_RST(4'b1001), .CNT_W(2)
    ) u_dut_sat (
        .clk(clk), .rst(rst), .b(b), .en(en), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DETECTOR_MASK_EN
        .mask_in(4'b1111),
`endif
        .clr(clr), .w(w2), .match_cnt(match_cnt2), .armed(armed2)
    );

    // Scoreboard monitor: pops the expectation pushed for the edge just taken.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks += 4;
            if (w !== e.w) begin
                errors++;
                $display("FAIL %s w: got %b expected %b", cur_test, w, e.w);
            end
            if (match_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s match_cnt: got %0d expected %0d", cur_test, match_cnt, e.cnt);
            end
            if (match_cnt2 !== e.cnt2) begin
                errors++;
                $display("FAIL %s match_cnt(W=2): got %0d expected %0d", cur_test, match_cnt2, e.cnt2);
            end
            if (armed !== e.armed) begin
                errors++;
                $display("FAIL %s armed: got %b expected %b", cur_test, armed, e.armed);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_hist = 4'b0000; m_pat = 4'b1001; m_fill = 0;
        m_cnt = 0; m_cnt2 = 0; m_w = 1'b0; m_armed = 1'b0;
        q.delete();
    endtask

    task automatic model_edge();
        logic [3:0] nh;
        logic       mt;
        if (clr) begin
            m_fill = 0; m_cnt = 0; m_cnt2 = 0; m_w = 1'b0; m_armed = 1'b0;
        end else if (pat_load) begin
            m_pat = pat_in; m_fill = 0; m_w = 1'b0; m_armed = 1'b0;
        end else if (en) begin
            nh = {m_hist[2:0], b};
            mt = (nh == m_pat) && (m_fill + 1 >= 4);
            m_hist = nh;
            m_w = mt;
            if (mt) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (mt && !overlap) m_fill = 0;
            else if (m_fill < 4) m_fill++;
            m_armed = (m_fill == 4);
        end else begin
            m_w = 1'b0;
        end
    endtask

    task automatic step(input logic bi, input logic eni);
        exp_t e;
        @(negedge clk);
        b = bi;
        en = eni;
        model_edge();
        e.w = m_w; e.cnt = m_cnt[7:0]; e.cnt2 = m_cnt2[1:0]; e.armed = m_armed;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1);
    endtask

    // Holds rst low across one edge, then releases on a falling edge.
    task automatic do_reset();
        en = 1'b0; clr = 1'b0; pat_load = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        checks += 3;
        if (w !== 1'b0) begin errors++; $display("FAIL %s rst w: got %b expected 0", cur_test, w); end
        if (match_cnt !== 8'd0) begin errors++; $display("FAIL %s rst match_cnt: got %0d expected 0", cur_test, match_cnt); end
        if (armed !== 1'b0) begin errors++; $display("FAIL %s rst armed: got %b expected 0", cur_test, armed); end
        @(posedge clk);
        #2;
        checks += 2;
        if (match_cnt2 !== 2'd0) begin errors++; $display("FAIL %s rst held match_cnt(W=2): got %0d expected 0", cur_test, match_cnt2); end
        if (w !== 1'b0) begin errors++; $display("FAIL %s rst held w: got %b expected 0", cur_test, w); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_overlap();
        cur_test = "overlap";
        do_reset();
        overlap = 1'b1;
        feed(16'b1001001, 7);
        checks++;
        if (match_cnt !== 8'd2) begin errors++; $display("FAIL %s final count: got %0d expected 2", cur_test, match_cnt); end
    endtask

    task automatic test_nonoverlap();
        cur_test = "nonoverlap";
        do_reset();
        overlap = 1'b0;
        feed(16'b1001001, 7);
        checks += 2;
        if (match_cnt !== 8'd1) begin errors++; $display("FAIL %s final count: got %0d expected 1", cur_test, match_cnt); end
        if (armed !== 1'b0) begin errors++; $display("FAIL %s final armed: got %b expected 0", cur_test, armed); end
        overlap = 1'b1;
    endtask

    task automatic test_enable_gap();
        cur_test = "enable_gap";
        do_reset();
        feed(16'b100, 3);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (match_cnt !== 8'd1) begin errors++; $display("FAIL %s final count: got %0d expected 1", cur_test, match_cnt); end
    endtask

    task automatic test_pat_load();
        cur_test = "pat_load";
        do_reset();
        pat_load = 1'b1;
        pat_in = 4'b0110;
        step(1'b1, 1'b1);
        pat_load = 1'b0;
        feed(16'b0110, 4);
        feed(16'b1001, 4);
        checks++;
        if (match_cnt !== 8'd1) begin errors++; $display("FAIL %s final count: got %0d expected 1", cur_test, match_cnt); end
    endtask

    task automatic test_saturation();
        cur_test = "saturation";
        do_reset();
        overlap = 1'b1;
        feed(16'b1001, 4);
        for (int k = 0; k < 4; k++) feed(16'b001, 3);
        checks += 2;
        if (match_cnt2 !== 2'd3) begin errors++; $display("FAIL %s W=2 count: got %0d expected 3", cur_test, match_cnt2); end
        if (match_cnt !== 8'd5) begin errors++; $display("FAIL %s W=8 count: got %0d expected 5", cur_test, match_cnt); end
        cur_test = "clr";
        clr = 1'b1;
        step(1'b1, 1'b1);
        clr = 1'b0;
        checks += 3;
        if (match_cnt !== 8'd0) begin errors++; $display("FAIL %s count: got %0d expected 0", cur_test, match_cnt); end
        if (match_cnt2 !== 2'd0) begin errors++; $display("FAIL %s W=2 count: got %0d expected 0", cur_test, match_cnt2); end
        if (armed !== 1'b0) begin errors++; $display("FAIL %s armed: got %b expected 0", cur_test, armed); end
    endtask

    task automatic test_back_to_back_reset();
        cur_test = "rst_while_w";
        do_reset();
        feed(16'b1001, 4);
        do_reset();
        cur_test = "rst_midpattern";
        feed(16'b100, 3);
        do_reset();
        step(1'b1, 1'b1);
        checks += 2;
        if (w !== 1'b0) begin errors++; $display("FAIL %s w after final bit: got %b expected 0", cur_test, w); end
        if (match_cnt !== 8'd0) begin errors++; $display("FAIL %s count: got %0d expected 0", cur_test, match_cnt); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_enable_gap();
        test_pat_load();
        test_saturation();
        test_back_to_back_reset();
        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
